// File: rtl/pmem_burst_responder_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types (pmem responder slice)
//
// Purpose: shared constants, enums and a small helper for the physical-memory
// burst responder. A cacheline is 256 bits and moves as 4 beats of 64 bits.
// The line address offset is 5 bits wide.
//
// Contents:
//   PMEM_BEATS       beats per line
//   PMEM_BEAT_W      width of one beat in bits
//   PMEM_LINE_OFF    number of byte-offset bits below the line index
//   PMEM_BEAT_BITS   width of the beat index
//   pmem_rsp_state_t responder FSM states
//   pmem_op_t        latched operation of the burst in flight
//   pmem_req_legal   legality test for a request seen in IDLE
// ---------------------------------------------------------------------------
package rv32i_types;

  localparam int PMEM_BEATS     = 4;
  localparam int PMEM_BEAT_W    = 64;
  localparam int PMEM_LINE_OFF  = 5;
  localparam int PMEM_BEAT_BITS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } pmem_rsp_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } pmem_op_t;

  // A request is legal only when a single direction is asked for and the
  // address points at the start of a line.
  function automatic logic pmem_req_legal(
    input logic                     rd,
    input logic                     wr,
    input logic [PMEM_LINE_OFF-1:0] offset
  );
    return !(rd && wr) && (offset == '0);
  endfunction

endpackage

// File: rtl/pmem_burst_responder_ram.sv
// ---------------------------------------------------------------------------
// burst_ram
//
// Purpose: single-port synchronous RAM that backs the cacheline store. There
// is one entry per beat, so the address is {line, beat}. Reads are registered:
// data for the address presented in cycle N appears on rdata in cycle N+1.
// When a read and a write hit the same cycle, the read returns the old value.
// The contents are not reset.
//
// Ports:
//   clk    in   clock
//   we     in   write enable, commits wdata at addr on the rising edge
//   addr   in   entry index, ADDR_W bits
//   wdata  in   write data, DATA_W bits
//   rdata  out  registered read data, DATA_W bits
// ---------------------------------------------------------------------------
module burst_ram
  import rv32i_types::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = PMEM_BEAT_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // One shared port: write when asked, and always read the same entry.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/pmem_burst_responder.sv
// ---------------------------------------------------------------------------
// pmem_burst_responder
//
// Purpose: answers the core's 4-beat pmem burst protocol from an internal
// line store. The store holds 2**ADDR_BITS lines. After a request is accepted
// in cycle T, the four beats appear in cycles T+LATENCY .. T+LATENCY+3. One
// quiet DONE cycle follows, and then the responder is idle again.
// Protocol misuse sets a sticky error flag, and only rst clears that flag.
//
// Parameters:
//   ADDR_BITS  log2 of the number of lines held
//   LATENCY    acceptance-to-first-beat distance in cycles, 1..255
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   pmem_read     in   line read request, held through the last beat
//   pmem_write    in   line write request, held through the last beat
//   pmem_address  in   line address, bits [4:0] must be zero
//   pmem_wdata    in   write beat, sampled in every write beat cycle
//   pmem_rdata    out  read beat, zero outside read beats
//   pmem_resp     out  beat strobe, high for 4 consecutive cycles per burst
//   pmem_err      out  sticky protocol-error flag
// ---------------------------------------------------------------------------
module pmem_burst_responder
  import rv32i_types::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [31:0]            pmem_address,
  input  logic [PMEM_BEAT_W-1:0] pmem_wdata,
  output logic [PMEM_BEAT_W-1:0] pmem_rdata,
  output logic                   pmem_resp,
  output logic                   pmem_err
);

  localparam int        RAM_AW    = ADDR_BITS + PMEM_BEAT_BITS;
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
  localparam bit        SKIP_WAIT = (LATENCY == 1);

  pmem_rsp_state_t           r_state;
  pmem_rsp_state_t           w_next;
  pmem_op_t                  r_op;
  logic [ADDR_BITS-1:0]      r_line;
  logic [PMEM_BEAT_BITS-1:0] r_beat;
  logic [7:0]                r_lat;
  logic                      r_err;

  logic                      w_req;
  logic                      w_accept;
  logic                      w_illegal;
  logic                      w_violation;
  logic [ADDR_BITS-1:0]      w_in_line;
  logic [PMEM_BEAT_BITS-1:0] w_beat_next;
  logic                      w_ram_we;
  logic [RAM_AW-1:0]         w_ram_addr;
  logic [PMEM_BEAT_W-1:0]    w_ram_rdata;
  logic                      w_unused_addr;

  // Address bits above the line index are dropped on purpose, so addresses
  // alias modulo the store size.
  assign w_in_line     = pmem_address[PMEM_LINE_OFF +: ADDR_BITS];
  assign w_unused_addr = ^pmem_address[31:PMEM_LINE_OFF+ADDR_BITS];

  assign w_req       = pmem_read | pmem_write;
  assign w_accept    = (r_state == IDLE) && w_req &&
                       pmem_req_legal(pmem_read, pmem_write,
                                      pmem_address[PMEM_LINE_OFF-1:0]);
  assign w_illegal   = (r_state == IDLE) && w_req &&
                       !pmem_req_legal(pmem_read, pmem_write,
                                       pmem_address[PMEM_LINE_OFF-1:0]);
  assign w_beat_next = r_beat + 2'd1;

  // While a burst is in flight, the initiator must keep asserting exactly
  // the request that was accepted. Any other pattern is flagged, but the
  // burst still runs to completion from the latched op and line.
  assign w_violation = ((r_state == WAIT) || (r_state == BURST)) &&
                       ((pmem_read  != (r_op == OP_READ)) ||
                        (pmem_write != (r_op == OP_WRITE)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. WAIT lasts LATENCY-1 cycles. With LATENCY of 1 there is
  // no WAIT cycle at all, and beat 0 is prefetched in the acceptance cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SKIP_WAIT ? BURST : WAIT;
      WAIT:    if (r_lat <= 8'd1) w_next = BURST;
      BURST:   if (r_beat == 2'd3) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs and RAM control. During a read, the RAM runs one beat ahead of
  // the strobe, because its output register supplies pmem_rdata directly.
  // During a write, the RAM is addressed at the current beat. Reset blocks
  // the write of the beat that is in progress.
  always_comb begin
    pmem_resp  = (r_state == BURST);
    pmem_rdata = ((r_state == BURST) && (r_op == OP_READ)) ? w_ram_rdata : '0;
    pmem_err   = r_err;
    w_ram_we   = (r_state == BURST) && (r_op == OP_WRITE) && !rst;
    case (r_state)
      IDLE:    w_ram_addr = {w_in_line, 2'd0};
      BURST:   w_ram_addr = (r_op == OP_WRITE) ? {r_line, r_beat}
                                               : {r_line, w_beat_next};
      default: w_ram_addr = {r_line, 2'd0};
    endcase
  end

  // Latched request, counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= OP_READ;
      r_line <= '0;
      r_beat <= '0;
      r_lat  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_illegal || w_violation) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= pmem_write ? OP_WRITE : OP_READ;
            r_line <= w_in_line;
            r_beat <= '0;
            r_lat  <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (r_lat != 8'd0) begin
            r_lat <= r_lat - 8'd1;
          end
        end
        BURST: begin
          r_beat <= w_beat_next;
        end
        default: begin
        end
      endcase
    end
  end

  burst_ram #(
    .ADDR_W (RAM_AW),
    .DATA_W (PMEM_BEAT_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (pmem_wdata),
    .rdata (w_ram_rdata)
  );

endmodule
